rv32i_boot_loader: RTL and testbench

//  Upstream of the rv32i core. Takes program words from the Pocket host bridge and writes

---
 rtl/rv32i_boot_loader_pkg.sv | 18 +
 rtl/rv32i_sync_fifo.sv | 66 ++++++
 rtl/rv32i_boot_loader.sv | 116 +++++++++++
 tb/tb_rv32i_boot_loader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_boot_loader_pkg.sv
// Shared types and helpers for the rv32i boot loader: loader FSM states, core boot PC
// and the bridge-to-imem byte swap.
package rv32i_boot_loader_pkg;

    typedef enum logic [1:0] {
        HOLD,
        LOAD,
        DRAIN,
        RUN
    } loader_state_e;

    localparam logic [31:0] BOOT_PC = 32'h8000_0000;

    function automatic logic [31:0] swap_bytes32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/rv32i_sync_fifo.sv
// Single-clock FIFO with synchronous flush; a push into a full FIFO is taken when a pop
// frees a slot in the same cycle.
module rv32i_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full  = (count_q == (PW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/rv32i_boot_loader.sv
// Loads a program image from the host bridge into instruction memory, holding the core in
// reset until every accepted word has been committed.
module rv32i_boot_loader
    import rv32i_boot_loader_pkg::*;
#(
    parameter int          IMEM_WORDS  = 4096,
    parameter logic [31:0] BRIDGE_BASE = 32'h0000_0000,
    parameter int          FIFO_DEPTH  = 4,
    parameter bit          SWAP_BYTES  = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          bridge_wr,
    input  logic [31:0]                   bridge_addr,
    input  logic [31:0]                   bridge_wr_data,
    input  logic                          dataslot_start,
    input  logic                          dataslot_done,
    output logic                          imem_we,
    input  logic                          imem_wready,
    output logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
    output logic [31:0]                   imem_wdata,
    output logic                          core_reset_n,
    output logic                          busy,
    output logic [15:0]                   load_count,
    output logic                          err
);

    localparam int AW = $clog2(IMEM_WORDS);

    loader_state_e state_q, state_d;
    logic          core_reset_n_q, core_reset_n_d;
    logic [15:0]   load_count_q, load_count_d;
    logic          err_q, err_d;

    logic [31:0]    offset;
    logic           in_window;
    logic           accepting, push, pop, drop;
    logic           fifo_full, fifo_empty;
    logic [AW+31:0] fifo_rdata;
    logic           unused_byte_lane;

    // Modulo-2^32 subtraction: addresses below the base wrap high and fall out of the window.
    assign offset           = bridge_addr - BRIDGE_BASE;
    assign in_window        = offset[31:2] < 30'(IMEM_WORDS);
    assign unused_byte_lane = ^offset[1:0];

    assign accepting = ((state_q == LOAD) || (state_q == DRAIN)) && !dataslot_start;
    assign pop       = !fifo_empty && imem_wready;
    assign push      = accepting && bridge_wr && in_window && (!fifo_full || pop);
    assign drop      = accepting && bridge_wr && !push;

    rv32i_sync_fifo #(
        .WIDTH (AW + 32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (dataslot_start),
        .push    (push),
        .wdata   ({offset[AW+1:2], SWAP_BYTES ? swap_bytes32(bridge_wr_data) : bridge_wr_data}),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= HOLD;
            core_reset_n_q <= 1'b0;
            load_count_q   <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            core_reset_n_q <= core_reset_n_d;
            load_count_q   <= load_count_d;
            err_q          <= err_d;
        end
    end

    // Start wins over done and restarts the load from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HOLD:    if (dataslot_start) state_d = LOAD;
            LOAD:    if (dataslot_start) state_d = LOAD;
                     else if (dataslot_done) state_d = DRAIN;
            DRAIN:   if (dataslot_start) state_d = LOAD;
                     else if (fifo_empty && !push) state_d = RUN;
            RUN:     if (dataslot_start) state_d = LOAD;
            default: state_d = HOLD;
        endcase
    end

    always_comb begin
        core_reset_n_d = (state_q == RUN) && !dataslot_start;
        load_count_d   = load_count_q;
        err_d          = err_q;
        if (dataslot_start) begin
            load_count_d = '0;
            err_d        = 1'b0;
        end else begin
            if (pop && (load_count_q != 16'hFFFF)) load_count_d = load_count_q + 16'd1;
            if (drop) err_d = 1'b1;
        end
        busy       = (state_q == LOAD) || (state_q == DRAIN);
        imem_we    = !fifo_empty;
        imem_addr  = fifo_empty ? '0 : fifo_rdata[AW+31:32];
        imem_wdata = fifo_empty ? '0 : fifo_rdata[31:0];
    end

    assign core_reset_n = core_reset_n_q;
    assign load_count   = load_count_q;
    assign err          = err_q;

endmodule

// File: tb/tb_rv32i_boot_loader.sv
// Bench for rv32i_boot_loader: directed image loads plus random traffic, checked every
// cycle against a queue-based model of the loader.
module tb_rv32i_boot_loader;
    import rv32i_boot_loader_pkg::*;

    localparam int          IMEM_WORDS  = 4096;
    localparam logic [31:0] BRIDGE_BASE = 32'h0000_0000;
    localparam int          FIFO_DEPTH  = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        bridge_wr, dataslot_start, dataslot_done, imem_wready;
    logic [31:0] bridge_addr, bridge_wr_data;
    logic        imem_we, core_reset_n, busy, err;
    logic [11:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [15:0] load_count;

    rv32i_boot_loader #(
        .IMEM_WORDS  (IMEM_WORDS),
        .BRIDGE_BASE (BRIDGE_BASE),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SWAP_BYTES  (1'b1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bridge_wr      (bridge_wr),
        .bridge_addr    (bridge_addr),
        .bridge_wr_data (bridge_wr_data),
        .dataslot_start (dataslot_start),
        .dataslot_done  (dataslot_done),
        .imem_we        (imem_we),
        .imem_wready    (imem_wready),
        .imem_addr      (imem_addr),
        .imem_wdata     (imem_wdata),
        .core_reset_n   (core_reset_n),
        .busy           (busy),
        .load_count     (load_count),
        .err            (err)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          w;
        logic [31:0] d;
    } ent_t;

    loader_state_e m_state;
    ent_t          q[$];
    bit            m_crn;
    logic [15:0]   m_cnt;
    bit            m_err;
    logic [31:0]   exp_mem [int];
    logic [31:0]   act_mem [int];

    always @(posedge clk or negedge reset_n) begin : model
        bit          was_empty, pop, push, crn_next;
        logic [31:0] off, sw;
        if (!reset_n) begin
            m_state = HOLD;
            q.delete();
            m_crn = 1'b0;
            m_cnt = '0;
            m_err = 1'b0;
        end else begin
            was_empty = (q.size() == 0);
            pop       = !was_empty && imem_wready;
            push      = 1'b0;
            crn_next  = (m_state == RUN) && !dataslot_start;
            if (pop) begin
                exp_mem[q[0].w] = q[0].d;
                void'(q.pop_front());
            end
            if (dataslot_start) begin
                q.delete();
                m_cnt   = '0;
                m_err   = 1'b0;
                m_state = LOAD;
            end else begin
                if (pop && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if ((m_state == LOAD || m_state == DRAIN) && bridge_wr) begin
                    off = bridge_addr - BRIDGE_BASE;
                    sw  = {<<8{bridge_wr_data}};
                    if (off / 4 >= 32'(IMEM_WORDS)) m_err = 1'b1;
                    else if (q.size() >= FIFO_DEPTH) m_err = 1'b1;
                    else begin
                        q.push_back('{w: int'(off / 4), d: sw});
                        push = 1'b1;
                    end
                end
                if (m_state == LOAD && dataslot_done) m_state = DRAIN;
                else if (m_state == DRAIN && was_empty && !push) m_state = RUN;
            end
            m_crn = crn_next;
        end
    end

    always @(negedge clk) begin : compare
        bit exp_we;
        if (reset_n === 1'b1) begin
            exp_we = (q.size() != 0);
            check("imem_we", imem_we, exp_we);
            if (exp_we) begin
                check("imem_addr", imem_addr, q[0].w);
                check("imem_wdata", imem_wdata, q[0].d);
            end
            check("core_reset_n", core_reset_n, m_crn);
            check("busy", busy, (m_state == LOAD) || (m_state == DRAIN));
            check("load_count", load_count, m_cnt);
            check("err", err, m_err);
            if (imem_we && imem_wready) act_mem[int'(imem_addr)] = imem_wdata;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit s, input bit d, input bit w, input logic [31:0] a,
                       input logic [31:0] dat);
        dataslot_start = s;
        dataslot_done  = d;
        bridge_wr      = w;
        bridge_addr    = a;
        bridge_wr_data = dat;
        @(posedge clk);
        #1;
        dataslot_start = 1'b0;
        dataslot_done  = 1'b0;
        bridge_wr      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wait_run();
        for (int i = 0; i < 60; i++) begin
            if (core_reset_n === 1'b1) break;
            idle(1);
        end
        check("wait_run_timeout", core_reset_n, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; bridge_wr = 1'b0; dataslot_start = 1'b0; dataslot_done = 1'b0;
        bridge_addr = '0; bridge_wr_data = '0; imem_wready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_imem_we", imem_we, 1'b0);
        check("rst_imem_addr", imem_addr, 12'h0);
        check("rst_imem_wdata", imem_wdata, 32'h0);
        check("rst_core_reset_n", core_reset_n, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_load_count", load_count, 16'h0);
        check("rst_err", err, 1'b0);
        reset_n = 1'b1;

        // 1: three words, done, RUN, core released one cycle after RUN
        imem_wready = 1'b1;
        cyc(1, 0, 0, 0, 0);
        check("t1_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'(i * 4), 32'h1300_0000);
        cyc(0, 1, 0, 0, 0);
        idle(1);
        check("t1_crn_in_run_entry", core_reset_n, 1'b0);
        idle(1);
        check("t1_crn_released", core_reset_n, 1'b1);
        for (int i = 0; i < 3; i++) check("t1_mem", act_mem[i], 32'h0000_0013);
        check("t1_load_count", load_count, 16'd3);

        // 2: back-pressure, 6 writes into a 4-deep FIFO
        cyc(1, 0, 0, 0, 0);
        imem_wready = 1'b0;
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 32'h100 + 32'(i * 4), $urandom());
        check("t2_err", err, 1'b1);
        check("t2_count_stalled", load_count, 16'd0);
        imem_wready = 1'b1;
        idle(4);
        check("t2_load_count", load_count, 16'd4);
        check("t2_drained", imem_we, 1'b0);
        cyc(0, 1, 0, 0, 0);
        wait_run();

        // 3: window boundary
        cyc(1, 0, 0, 0, 0);
        imem_wready = 1'b0;
        cyc(0, 0, 1, 32'h0000_4000, 32'h1234_5678);
        check("t3_err", err, 1'b1);
        check("t3_no_we", imem_we, 1'b0);
        cyc(0, 0, 1, 32'h0000_3FFC, 32'hDEAD_BEEF);
        check("t3_we", imem_we, 1'b1);
        check("t3_addr", imem_addr, 12'hFFF);
        check("t3_wdata", imem_wdata, 32'hEFBE_ADDE);
        imem_wready = 1'b1;
        cyc(0, 1, 0, 0, 0);
        wait_run();

        // 4a: done together with the last write
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 1, 32'h10, 32'hA1B2_C3D4);
        check("t4_busy_drain", busy, 1'b1);
        wait_run();
        check("t4_mem4", act_mem[4], 32'hD4C3_B2A1);

        // 4b: done alone with words still queued stays in DRAIN
        cyc(1, 0, 0, 0, 0);
        imem_wready = 1'b0;
        cyc(0, 0, 1, 32'h20, $urandom());
        cyc(0, 0, 1, 32'h24, $urandom());
        cyc(0, 0, 1, 32'h8000_0000, $urandom());
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("t4_hold_drain", busy, 1'b1);
        end
        imem_wready = 1'b1;
        wait_run();

        // 5: restart from RUN, then a second image
        check("t5_err_before", err, 1'b1);
        cyc(1, 0, 0, 0, 0);
        check("t5_crn_low", core_reset_n, 1'b0);
        check("t5_count_clr", load_count, 16'd0);
        check("t5_err_clr", err, 1'b0);
        cyc(0, 0, 1, 32'h40, 32'h1122_3344);
        for (int i = 1; i < 4; i++) cyc(0, 0, 1, 32'h40 + 32'(i * 4), $urandom());
        cyc(0, 1, 0, 0, 0);
        wait_run();
        check("t5_mem16", act_mem[16], 32'h4433_2211);
        check("t5_load_count", load_count, 16'd4);

        // 6: reset in the middle of DRAIN
        cyc(1, 0, 0, 0, 0);
        imem_wready = 1'b0;
        cyc(0, 0, 1, 32'h80, $urandom());
        cyc(0, 0, 1, 32'h84, $urandom());
        cyc(0, 1, 0, 0, 0);
        idle(1);
        check("t6_draining", imem_we, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_we", imem_we, 1'b0);
        check("t6_rst_crn", core_reset_n, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_count", load_count, 16'd0);
        check("t6_rst_addr", imem_addr, 12'h0);
        imem_wready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1);
            check("t6_no_we", imem_we, 1'b0);
        end

        // random traffic
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            int          r;
            r = $urandom_range(9);
            if (r == 0) a = $urandom();
            else if (r == 1) a = BRIDGE_BASE + (($urandom_range(1) == 0) ? 32'h3FFC : 32'h4000);
            else a = BRIDGE_BASE + (32'($urandom_range(63)) << 2) + 32'($urandom_range(3));
            imem_wready = ($urandom_range(99) < 70);
            cyc($urandom_range(99) < 2, $urandom_range(99) < 4, $urandom_range(99) < 55,
                a, $urandom());
        end
        imem_wready = 1'b1;
        cyc(0, 1, 0, 0, 0);
        wait_run();
        foreach (exp_mem[k]) check("mem_final", act_mem.exists(k) ? act_mem[k] : 32'hx, exp_mem[k]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
